// File: rtl/router_fsm_ctrl_n.sv
// router_fsm_ctrl_n: 1xN packet-router control FSM.
// Decodes the header address, sequences header/payload/parity writes into the
// addressed FIFO, stalls on FIFO full, and drops packets that carry an invalid
// address or that wait too long for their FIFO to drain.
//
// state              | meaning
// -------------------+--------------------------------------------------
// S_DECODE           | idle, sampling header address on pkt_valid
// S_LFD              | writing header byte into addressed FIFO
// S_LD               | writing payload bytes
// S_WAIT             | addressed FIFO not yet empty, holding the source
// S_LP               | writing parity byte
// S_CPE              | parity check, internal register reset
// S_FULL             | addressed FIFO full, holding the source
// S_LAF              | resuming after a full stall
// S_DROP             | discarding bytes of a rejected packet
module router_fsm_ctrl_n #(
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] din,
  input  logic              fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_rst,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              wr_en_req,
  output logic              detect_addr,
  output logic              ld_state,
  output logic              laf_state,
  output logic              lfd_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              busy,
  output logic [ADDR_W-1:0] dest,
  output logic              drop_pkt,
  output logic              timeout_err
);

  // Counter needs at least one bit even when the timeout is disabled.
  localparam int CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(WAIT_TIMEOUT);
  localparam logic [ADDR_W:0]   NUM_CH_V = (ADDR_W + 1)'(NUM_CH);

  typedef enum logic [3:0] {
    S_DECODE = 4'd0,
    S_LFD    = 4'd1,
    S_LD     = 4'd2,
    S_WAIT   = 4'd3,
    S_LP     = 4'd4,
    S_CPE    = 4'd5,
    S_FULL   = 4'd6,
    S_LAF    = 4'd7,
    S_DROP   = 4'd8
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             empty_dest;
  logic             srst_dest;
  logic             empty_din;
  logic             din_ok;
  logic             wait_hit;
  logic             timeout_take;

  assign din_ok   = ({1'b0, din} < NUM_CH_V);
  assign wait_hit = (WAIT_TIMEOUT != 0) && (wait_cnt == CNT_MAX);

  // Per-channel flag select for the latched destination and the incoming header.
  always_comb begin
    empty_dest = 1'b0;
    srst_dest  = 1'b0;
    empty_din  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (dest == ADDR_W'(i)) begin
        empty_dest = fifo_empty[i];
        srst_dest  = soft_rst[i];
      end
      if (din == ADDR_W'(i)) begin
        empty_din = fifo_empty[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_DECODE;
    else     state <= state_nxt;
  end

  // Destination latch, captured only for a legal header address.
  always_ff @(posedge clk) begin
    if (rst)                                             dest <= '0;
    else if (state == S_DECODE && pkt_valid && din_ok)   dest <= din;
  end

  // Wait counter: held at zero outside S_WAIT, saturating count inside it.
  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT) wait_cnt <= '0;
    else if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // Next-state logic; soft reset of the active channel beats normal sequencing.
  always_comb begin
    state_nxt    = state;
    timeout_take = 1'b0;
    if (state != S_DECODE && srst_dest) begin
      state_nxt = S_DECODE;
    end else begin
      unique case (state)
        S_DECODE: begin
          if (pkt_valid) begin
            if (!din_ok)        state_nxt = S_DROP;
            else if (empty_din) state_nxt = S_LFD;
            else                state_nxt = S_WAIT;
          end
        end
        S_LFD:  state_nxt = S_LD;
        S_LD: begin
          if (fifo_full)       state_nxt = S_FULL;
          else if (!pkt_valid) state_nxt = S_LP;
        end
        S_WAIT: begin
          if (empty_dest) begin
            state_nxt = S_LFD;
          end else if (wait_hit) begin
            state_nxt    = S_DROP;
            timeout_take = 1'b1;
          end
        end
        S_LP:   state_nxt = S_CPE;
        S_CPE:  state_nxt = fifo_full ? S_FULL : S_DECODE;
        S_FULL: if (!fifo_full) state_nxt = S_LAF;
        S_LAF: begin
          if (parity_done)        state_nxt = S_DECODE;
          else if (low_pkt_valid) state_nxt = S_LP;
          else                    state_nxt = S_LD;
        end
        S_DROP: if (!pkt_valid) state_nxt = S_DECODE;
        default: state_nxt = S_DECODE;
      endcase
    end
  end

  // Moore status decode; timeout_err flags the cycle that commits the drop.
  always_comb begin
    detect_addr = (state == S_DECODE);
    lfd_state   = (state == S_LFD);
    ld_state    = (state == S_LD);
    laf_state   = (state == S_LAF);
    full_state  = (state == S_FULL);
    rst_int_reg = (state == S_CPE);
    drop_pkt    = (state == S_DROP);
    wr_en_req   = (state == S_LD) || (state == S_LP) || (state == S_LAF);
    busy        = !((state == S_DECODE) || (state == S_LD) || (state == S_DROP));
    timeout_err = timeout_take && !rst;
  end

endmodule

// File: tb/tb_router_fsm_ctrl_n.sv
// Bench for router_fsm_ctrl_n: directed packet scenarios followed by random
// traffic, all checked against a behavioural packet-phase model.
module tb_router_fsm_ctrl_n;

  localparam int NUM_CH = 3;
  localparam int ADDR_W = 2;
  localparam int TO     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              pkt_valid;
  logic [ADDR_W-1:0] din;
  logic              fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] soft_rst;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              wr_en_req, detect_addr, ld_state, laf_state, lfd_state;
  logic              full_state, rst_int_reg, busy, drop_pkt, timeout_err;
  logic [ADDR_W-1:0] dest;

  always #5 clk = ~clk;

  router_fsm_ctrl_n #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WAIT_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_rst(soft_rst),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .wr_en_req(wr_en_req), .detect_addr(detect_addr), .ld_state(ld_state),
    .laf_state(laf_state), .lfd_state(lfd_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .busy(busy), .dest(dest), .drop_pkt(drop_pkt),
    .timeout_err(timeout_err)
  );

  // Packet phases of the reference model.
  typedef enum int {P_IDLE, P_FIRST, P_BODY, P_WAIT, P_PAR, P_CHK, P_FULL, P_AFTER, P_DROP} phase_t;

  phase_t m_phase = P_IDLE;
  int     m_dest  = 0;
  int     m_wait  = 0;
  bit     m_known = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int cnt_lfd, cnt_ld, cnt_wr, cnt_to, to_at, tick_no = 0, base;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_timeout();
    return !rst && m_phase == P_WAIT && !fifo_empty[m_dest] && !soft_rst[m_dest]
           && TO != 0 && m_wait == TO;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_phase = P_IDLE; m_dest = 0; m_wait = 0; m_known = 1'b1;
      return;
    end
    if (!m_known) return;
    if (m_phase != P_IDLE && soft_rst[m_dest]) begin
      m_phase = P_IDLE;
      return;
    end
    case (m_phase)
      P_IDLE: if (pkt_valid) begin
        if (int'(din) >= NUM_CH) m_phase = P_DROP;
        else begin
          m_dest  = int'(din);
          m_wait  = 0;
          m_phase = fifo_empty[din] ? P_FIRST : P_WAIT;
        end
      end
      P_FIRST: m_phase = P_BODY;
      P_BODY:  if (fifo_full) m_phase = P_FULL; else if (!pkt_valid) m_phase = P_PAR;
      P_WAIT: begin
        if (fifo_empty[m_dest])           m_phase = P_FIRST;
        else if (TO != 0 && m_wait >= TO) m_phase = P_DROP;
        else if (m_wait < TO)             m_wait++;
      end
      P_PAR:   m_phase = P_CHK;
      P_CHK:   m_phase = fifo_full ? P_FULL : P_IDLE;
      P_FULL:  if (!fifo_full) m_phase = P_AFTER;
      P_AFTER: m_phase = parity_done ? P_IDLE : (low_pkt_valid ? P_PAR : P_BODY);
      P_DROP:  if (!pkt_valid) m_phase = P_IDLE;
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic check_outs();
    if (!m_known) return;
    chk("detect_addr", 32'(detect_addr), 32'(m_phase == P_IDLE));
    chk("lfd_state",   32'(lfd_state),   32'(m_phase == P_FIRST));
    chk("ld_state",    32'(ld_state),    32'(m_phase == P_BODY));
    chk("laf_state",   32'(laf_state),   32'(m_phase == P_AFTER));
    chk("full_state",  32'(full_state),  32'(m_phase == P_FULL));
    chk("rst_int_reg", 32'(rst_int_reg), 32'(m_phase == P_CHK));
    chk("drop_pkt",    32'(drop_pkt),    32'(m_phase == P_DROP));
    chk("wr_en_req",   32'(wr_en_req),   32'(m_phase == P_BODY || m_phase == P_PAR || m_phase == P_AFTER));
    chk("busy",        32'(busy),        32'(!(m_phase == P_IDLE || m_phase == P_BODY || m_phase == P_DROP)));
    chk("dest",        32'(dest),        32'(m_dest));
    cnt_lfd += int'(lfd_state);
    cnt_ld  += int'(ld_state);
    cnt_wr  += int'(wr_en_req);
  endtask

  // One clock: check the combinational pulse against current inputs, let the
  // edge happen, advance the model, then check the registered outputs.
  task automatic tick();
    #1;
    if (m_known) begin
      chk("timeout_err", 32'(timeout_err), 32'(exp_timeout()));
      if (timeout_err) begin
        cnt_to++;
        to_at = tick_no;
      end
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outs();
    tick_no++;
  endtask

  task automatic clr();
    rst = 1'b0; pkt_valid = 1'b0; fifo_full = 1'b0; soft_rst = '0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
    cnt_lfd = 0; cnt_ld = 0; cnt_wr = 0; cnt_to = 0; to_at = -1;
  endtask

  initial begin
    clr();
    din = '0; fifo_empty = '0;
    @(negedge clk);

    // Reset
    rst = 1'b1; tick(); tick();
    chk("rst_detect", 32'(detect_addr), 32'd1);
    chk("rst_dest",   32'(dest),        32'd0);

    // Normal packet to channel 2
    clr(); pkt_valid = 1'b1; din = 2'd2; fifo_empty = 3'b100;
    tick();
    chk("norm_dest", 32'(dest), 32'd2);
    repeat (4) tick();
    pkt_valid = 1'b0; tick();
    tick();
    chk("norm_rst_int", 32'(rst_int_reg), 32'd1);
    tick();
    chk("norm_lfd_cycles", 32'(cnt_lfd), 32'd1);
    chk("norm_ld_cycles",  32'(cnt_ld),  32'd4);
    chk("norm_back_idle",  32'(detect_addr), 32'd1);

    // Wait only on the addressed channel
    clr(); pkt_valid = 1'b1; din = 2'd1; fifo_empty = 3'b101;
    tick();
    chk("tw_busy", 32'(busy), 32'd1);
    repeat (2) tick();
    chk("tw_no_lfd", 32'(cnt_lfd), 32'd0);
    fifo_empty = 3'b111; tick();
    chk("tw_lfd", 32'(lfd_state), 32'd1);
    pkt_valid = 1'b0;
    repeat (4) tick();

    // Timeout drop
    clr(); pkt_valid = 1'b1; din = 2'd0; fifo_empty = 3'b000;
    tick();
    base = tick_no;
    repeat (7) tick();
    chk("to_pulses", 32'(cnt_to), 32'd1);
    chk("to_delay",  32'(to_at - base), 32'd4);
    chk("to_drop",   32'(drop_pkt), 32'd1);
    chk("to_busy",   32'(busy), 32'd0);
    pkt_valid = 1'b0; tick();
    chk("to_idle",   32'(detect_addr), 32'd1);
    chk("to_no_wr",  32'(cnt_wr), 32'd0);

    // Invalid address
    clr(); pkt_valid = 1'b1; din = 2'd3; fifo_empty = 3'b111;
    tick();
    chk("inv_drop", 32'(drop_pkt), 32'd1);
    repeat (2) tick();
    pkt_valid = 1'b0; tick();
    chk("inv_idle",  32'(detect_addr), 32'd1);
    chk("inv_no_wr", 32'(cnt_wr), 32'd0);

    // Full handling, resuming into parity
    clr(); pkt_valid = 1'b1; din = 2'd0; fifo_empty = 3'b001;
    tick(); tick();
    fifo_full = 1'b1; tick();
    chk("full_state", 32'(full_state), 32'd1);
    chk("full_busy",  32'(busy), 32'd1);
    tick();
    fifo_full = 1'b0; tick();
    chk("full_laf", 32'(laf_state), 32'd1);
    low_pkt_valid = 1'b1; tick();
    chk("full_to_parity", 32'(wr_en_req & busy), 32'd1);
    low_pkt_valid = 1'b0; pkt_valid = 1'b0;
    tick(); tick();

    // Full and end-of-packet together, then parity_done
    pkt_valid = 1'b1; tick(); tick();
    pkt_valid = 1'b0; fifo_full = 1'b1; tick();
    chk("full_wins", 32'(full_state), 32'd1);
    fifo_full = 1'b0; tick();
    parity_done = 1'b1; tick();
    chk("pd_idle", 32'(detect_addr), 32'd1);
    parity_done = 1'b0;

    // Soft reset of the active channel
    clr(); pkt_valid = 1'b1; din = 2'd1; fifo_empty = 3'b010;
    tick(); tick();
    soft_rst = 3'b010; tick();
    chk("srst_idle", 32'(detect_addr), 32'd1);
    soft_rst = 3'b000;

    // Soft reset of other channels is ignored, then hard reset mid-stall
    tick(); tick();
    soft_rst = 3'b101; tick();
    chk("srst_other", 32'(ld_state), 32'd1);
    soft_rst = 3'b000; fifo_full = 1'b1; tick();
    rst = 1'b1; tick();
    chk("rst_full_state", 32'(full_state), 32'd0);
    chk("rst_mid_detect", 32'(detect_addr), 32'd1);
    chk("rst_mid_dest",   32'(dest), 32'd0);
    chk("rst_mid_busy",   32'(busy), 32'd0);
    clr();
    tick();

    // Random traffic
    repeat (3000) begin
      rst           = ($urandom_range(0, 63) == 0);
      pkt_valid     = ($urandom_range(0, 3) != 0);
      din           = 2'($urandom_range(0, 3));
      fifo_full     = ($urandom_range(0, 3) == 0);
      parity_done   = ($urandom_range(0, 7) == 0);
      low_pkt_valid = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        fifo_empty[i] = ($urandom_range(0, 3) == 0);
        soft_rst[i]   = ($urandom_range(0, 31) == 0);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/router_fsm_ctrl_n.md
# router_fsm_ctrl_n

Parametrised packet-router control FSM for a 1xN router: decodes the header address, sequences header/payload/parity writes into the addressed output FIFO, and handles FIFO-full stalls. It sits between the input register stage and the output synchroniser/FIFO bank. It generalises the 1x3 controller in three ways:
- any channel count;
- waiting on the addressed FIFO only;
- dropping packets that have an invalid address or that time out waiting for their FIFO to empty.

## Interface
Parameters:
- NUM_CH, 3, number of output channels/FIFOs (2..16)
- ADDR_W, 2, header address width; must satisfy 2**ADDR_W >= NUM_CH
- WAIT_TIMEOUT, 32, max cycles in WAIT_TILL_EMPTY before drop; 0 disables timeout

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pkt_valid  in  1  source presenting packet bytes
- din  in  ADDR_W  header address bits (sampled in DECODE_ADDRESS)
- fifo_full  in  1  addressed FIFO full (from synchroniser)
- fifo_empty  in  NUM_CH  per-channel FIFO empty
- soft_rst  in  NUM_CH  per-channel soft reset (read timeout in synchroniser)
- parity_done  in  1  parity byte written (from register block)
- low_pkt_valid  in  1  pkt_valid fell while in full handling
- wr_en_req  out  1  request FIFO write
- detect_addr  out  1  in DECODE_ADDRESS
- ld_state  out  1  in LOAD_DATA
- laf_state  out  1  in LOAD_AFTER_FULL
- lfd_state  out  1  in LOAD_FIRST_DATA
- full_state  out  1  in FIFO_FULL_STATE
- rst_int_reg  out  1  in CHECK_PARITY_ERROR
- busy  out  1  source must hold current byte
- dest  out  ADDR_W  latched destination channel
- drop_pkt  out  1  in DROP_PACKET (input bytes discarded)
- timeout_err  out  1  one-cycle pulse on wait timeout

## Operation
- **States:** DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, WAIT_TILL_EMPTY, LOAD_PARITY, CHECK_PARITY_ERROR, FIFO_FULL_STATE, LOAD_AFTER_FULL, DROP_PACKET. Use a 4-bit encoding; any illegal code returns to DECODE_ADDRESS.
- **DECODE_ADDRESS:**
  - On pkt_valid with din >= NUM_CH: go to DROP_PACKET.
  - On pkt_valid with din valid: latch dest <= din. Go to LOAD_FIRST_DATA if fifo_empty[din] is 1, otherwise WAIT_TILL_EMPTY.
  - Otherwise stay.
- **LOAD_FIRST_DATA:** unconditionally go to LOAD_DATA.
- **LOAD_DATA:** fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
- **WAIT_TILL_EMPTY:**
  - fifo_empty[dest] -> LOAD_FIRST_DATA. Empty flags of other channels are ignored.
  - Otherwise, when the wait counter reaches WAIT_TIMEOUT (and WAIT_TIMEOUT != 0) -> DROP_PACKET, with timeout_err asserted for exactly that transition cycle.
- **FIFO_FULL_STATE:** !fifo_full -> LOAD_AFTER_FULL; else stay.
- **LOAD_AFTER_FULL:** parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY; else LOAD_DATA.
- **LOAD_PARITY:** unconditionally go to CHECK_PARITY_ERROR.
- **CHECK_PARITY_ERROR:** fifo_full -> FIFO_FULL_STATE; else DECODE_ADDRESS.
- **DROP_PACKET:** stay while pkt_valid; !pkt_valid -> DECODE_ADDRESS. No write requests are issued. The trailing parity byte arrives with pkt_valid=0 and is ignored in DECODE_ADDRESS.
- **Wait counter:**
  - Width is $clog2(WAIT_TIMEOUT+1).
  - Cleared on entry to WAIT_TILL_EMPTY; increments each cycle spent there; saturates.
- **Outputs** are Moore, decoded from the state register:
  - wr_en_req = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = every state except DECODE_ADDRESS, LOAD_DATA and DROP_PACKET.

## Timing
- One state transition per clk. Outputs change the cycle after the deciding input is sampled.
- **Header to first write:** pkt_valid with an empty FIFO at edge N gives lfd_state=1 in cycle N+1 and ld_state=1 in cycle N+2.
- **Reset:** rst=1 at an edge sets state to DECODE_ADDRESS, dest=0 and counter=0. Resulting outputs: detect_addr=1; all other outputs 0. Reset overrides everything, including mid-packet.
- **Soft reset:**
  - soft_rst[dest]=1 in any state other than DECODE_ADDRESS forces DECODE_ADDRESS at the next edge.
  - soft_rst on any other channel is ignored.
  - Priority order is rst > soft_rst[dest] > next-state logic.
- **Simultaneous events:**
  - In WAIT_TILL_EMPTY, if fifo_empty[dest] and timeout coincide, empty wins and no timeout_err is raised.
  - In LOAD_DATA, if fifo_full and !pkt_valid coincide, full wins.
- With WAIT_TIMEOUT=0 the controller waits in WAIT_TILL_EMPTY indefinitely.

## Test plan
- **Normal packet:** rst, then pkt_valid, din=2, fifo_empty=3'b100, 4 payload bytes, then pkt_valid=0. Required: dest=2; lfd_state 1 cycle; ld_state 4 cycles; LOAD_PARITY, then CHECK_PARITY_ERROR with rst_int_reg=1; back to detect_addr=1.
- **Targeted wait:** din=1, fifo_empty=3'b101. Required: busy=1 and state stays WAIT_TILL_EMPTY despite channels 0/2 being empty. Set fifo_empty[1]=1 -> lfd_state next cycle.
- **Timeout drop:** WAIT_TIMEOUT=4, din=0, fifo_empty[0] held 0. Required: timeout_err pulses exactly once, 4 cycles after WAIT entry; drop_pkt=1 and busy=0 until pkt_valid falls; wr_en_req never asserted.
- **Invalid address:** NUM_CH=3, din=3. Required: DROP_PACKET immediately, no write requests, returns to DECODE_ADDRESS after pkt_valid=0.
- **Full handling:** assert fifo_full in LOAD_DATA. Required: full_state=1 with busy=1. Deassert fifo_full -> laf_state=1. Then:
  - with low_pkt_valid=1 -> LOAD_PARITY;
  - repeat with parity_done=1 -> DECODE_ADDRESS.
- **Resets mid-packet:**
  - soft_rst[dest] in LOAD_DATA -> detect_addr=1 next cycle.
  - soft_rst on a non-dest channel -> no effect.
  - rst in FIFO_FULL_STATE -> all outputs at reset values next cycle.
